// File: rtl/lbm_fixed_pkg.sv
// Shared fixed-point definitions for the LBM datapath: Q-format defaults,
// saturation limits and the accumulator FSM state type.
package lbm_fixed_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int FRACTIONAL_BITS = 56;

    typedef logic signed [DATA_WIDTH-1:0] q_t;

    localparam q_t Q_ONE = q_t'(64'd1 << FRACTIONAL_BITS);
    localparam q_t Q_MAX = q_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam q_t Q_MIN = q_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_t;

endpackage

// File: rtl/fp_mult.sv
// Combinational signed fixed-point multiplier. Keeps the [2F+I-1:F] slice of
// the full product: rounds toward minus infinity, wraps on integer overflow.
module fp_mult #(
    parameter int DATA_WIDTH      = 64,
    parameter int FRACTIONAL_BITS = 56
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] p
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] full;

    assign full = PW'(a) * PW'(b);
    // Arithmetic shift then truncate: floor rounding, modular integer wrap.
    assign p    = DATA_WIDTH'(full >>> FRACTIONAL_BITS);

endmodule

// File: rtl/fp_dot_acc.sv
// Pipelined fixed-point dot-product accumulator: one registered multiply
// stage, then a guarded accumulator that emits one saturated sum per packet.
module fp_dot_acc #(
    parameter int DATA_WIDTH      = lbm_fixed_pkg::DATA_WIDTH,
    parameter int FRACTIONAL_BITS = lbm_fixed_pkg::FRACTIONAL_BITS,
    parameter int MAX_TERMS       = 9,
    parameter int GUARD_BITS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_ovf,
    output logic                  out_len_err,
    output logic [3:0]            out_count
);

    import lbm_fixed_pkg::*;

    localparam int         AW       = DATA_WIDTH + GUARD_BITS;
    localparam logic [3:0] LAST_CNT = 4'(MAX_TERMS);

    acc_state_t state, state_next;

    logic                         accept;
    logic                         p_valid, p_last, p_end;
    logic signed [DATA_WIDTH-1:0] mult_out, p_prod;
    logic signed [AW-1:0]         acc, acc_next, sum;
    logic [3:0]                   cnt, cnt_next, cnt_inc;
    logic                         load_out;
    logic                         pos_ovf, neg_ovf;
    logic [DATA_WIDTH-1:0]        sat_sum;

    fp_mult #(
        .DATA_WIDTH      (DATA_WIDTH),
        .FRACTIONAL_BITS (FRACTIONAL_BITS)
    ) u_mult (
        .a (in_a),
        .b (in_b),
        .p (mult_out)
    );

    assign cnt_inc  = cnt + 4'd1;
    assign p_end    = p_last || (cnt_inc == LAST_CNT);
    assign in_ready = (state == ACC) && !(p_valid && p_end);
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) p_last <= in_last;
        end
    end

    // NOTE: the product register is data only, qualified by p_valid, so it
    // carries no reset; this keeps the wide datapath free of reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) p_prod <= mult_out;
    end

    assign sum     = acc + AW'(p_prod);
    assign pos_ovf = !sum[AW-1] && (|sum[AW-2:DATA_WIDTH-1]);
    assign neg_ovf =  sum[AW-1] && !(&sum[AW-2:DATA_WIDTH-1]);

    always_comb begin
        sat_sum = sum[DATA_WIDTH-1:0];
        if (pos_ovf)      sat_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (neg_ovf) sat_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        load_out   = 1'b0;
        unique case (state)
            ACC: begin
                if (p_valid) begin
                    if (p_end) begin
                        acc_next   = '0;
                        cnt_next   = '0;
                        load_out   = 1'b1;
                        state_next = DONE;
                    end else begin
                        acc_next = sum;
                        cnt_next = cnt_inc;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_ovf     <= 1'b0;
            out_len_err <= 1'b0;
            out_count   <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (load_out) begin
                out_valid   <= 1'b1;
                out_sum     <= sat_sum;
                out_ovf     <= pos_ovf || neg_ovf;
                out_len_err <= !p_last;
                out_count   <= cnt_inc;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
